// File: rtl/load_store_unit_pkg.sv
// Shared types, funct3 codes and access legality helpers for the load/store unit.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } lsu_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'b00,
        CAUSE_MISALIGNED = 2'b01,
        CAUSE_TIMEOUT    = 2'b10,
        CAUSE_ILLEGAL    = 2'b11
    } fault_cause_t;

    // Store encodings SB/SH/SW share the LB/LH/LW codes.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    function automatic logic is_illegal(input logic [2:0] funct3, input logic write);
        logic result;
        case (funct3)
            F3_LB, F3_LH, F3_LW: result = 1'b0;
            F3_LBU, F3_LHU:      result = write;
            default:             result = 1'b1;
        endcase
        return result;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        logic result;
        case (funct3)
            F3_LH, F3_LHU: result = offset[0];
            F3_LW:         result = (offset != 2'b00);
            default:       result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory request/response bus between the load/store unit and memory.
interface load_store_unit_if;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_we, mem_be, mem_address, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_we, mem_be, mem_address, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/load_store_unit_load_extender.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends it.
module load_extender
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] data
);
    logic [7:0]  lanes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = lanes[offset];
    assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        data = rdata;
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {24'h000000, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data = {16'h0000, half_sel};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: validates the access, runs one memory transaction
// with a timeout, and returns the extended load result in a one-cycle DONE slot.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_address,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic [31:0]       rsp_rdata,
    output logic              fault,
    output logic [1:0]        fault_cause,
    load_store_unit_if.master bus
);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_t   state_reg, state_next;
    fault_cause_t cause_reg, cause_next;
    logic [31:0]  addr_reg, wdata_reg, rsp_rdata_reg;
    logic [2:0]   funct3_reg;
    logic         write_reg;
    logic [7:0]   cnt_reg;
    logic         load_ok, timeout_hit, accept, enter_done;
    logic [3:0]   be_calc;
    logic [31:0]  store_data, ext_data;

    load_extender u_load_extender (
        .funct3 (funct3_reg),
        .offset (addr_reg[1:0]),
        .rdata  (bus.mem_rdata),
        .data   (ext_data)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state_reg <= ST_IDLE;
        else          state_reg <= state_next;
    end

    assign timeout_hit = (cnt_reg >= TIMEOUT_LAST);

    always_comb begin
        state_next = state_reg;
        cause_next = CAUSE_NONE;
        load_ok    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    if (is_illegal(req_funct3, req_write)) begin
                        state_next = ST_DONE;
                        cause_next = CAUSE_ILLEGAL;
                    end else if (is_misaligned(req_funct3, req_address[1:0])) begin
                        state_next = ST_DONE;
                        cause_next = CAUSE_MISALIGNED;
                    end else begin
                        state_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (bus.mem_ready) begin
                    if (write_reg) begin
                        state_next = ST_DONE;
                    end else if (bus.mem_rvalid) begin
                        state_next = ST_DONE;
                        load_ok    = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end else if (timeout_hit) begin
                    state_next = ST_DONE;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            ST_WAIT: begin
                if (bus.mem_rvalid) begin
                    state_next = ST_DONE;
                    load_ok    = 1'b1;
                end else if (timeout_hit) begin
                    state_next = ST_DONE;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign accept     = (state_reg == ST_IDLE) && (state_next == ST_REQ);
    assign enter_done = (state_reg != ST_DONE) && (state_next == ST_DONE);

    // Result is latched on the way into DONE; anything but a completed load reads as zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_reg      <= '0;
            wdata_reg     <= '0;
            funct3_reg    <= '0;
            write_reg     <= 1'b0;
            cnt_reg       <= '0;
            rsp_rdata_reg <= '0;
            cause_reg     <= CAUSE_NONE;
        end else begin
            if (accept) begin
                addr_reg   <= req_address;
                wdata_reg  <= req_wdata;
                funct3_reg <= req_funct3;
                write_reg  <= req_write;
                cnt_reg    <= '0;
            end else if (state_reg == ST_REQ || state_reg == ST_WAIT) begin
                cnt_reg <= cnt_reg + 8'd1;
            end
            if (enter_done) begin
                cause_reg     <= cause_next;
                rsp_rdata_reg <= load_ok ? ext_data : '0;
            end
        end
    end

    always_comb begin
        be_calc    = 4'b1111;
        store_data = wdata_reg;
        if (write_reg) begin
            case (funct3_reg)
                F3_LB: begin
                    be_calc    = 4'b0001 << addr_reg[1:0];
                    store_data = {4{wdata_reg[7:0]}};
                end
                F3_LH: begin
                    be_calc    = addr_reg[1] ? 4'b1100 : 4'b0011;
                    store_data = {2{wdata_reg[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.mem_valid   = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_be      = 4'b0000;
        bus.mem_address = {addr_reg[31:2], 2'b00};
        bus.mem_wdata   = store_data;
        fault           = 1'b0;
        fault_cause     = CAUSE_NONE;
        if (state_reg == ST_REQ) begin
            bus.mem_valid = 1'b1;
            bus.mem_we    = write_reg;
            bus.mem_be    = be_calc;
        end
        if (state_reg == ST_DONE) begin
            fault_cause = cause_reg;
            fault       = (cause_reg != CAUSE_NONE);
        end
    end

    assign stall     = req_valid && (state_reg != ST_DONE);
    assign rsp_rdata = rsp_rdata_reg;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit with an inline memory responder.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_address = '0;
    logic [31:0] req_wdata = '0;
    logic        stall, fault;
    logic [31:0] rsp_rdata;
    logic [1:0]  fault_cause;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic [1:0]  cause;
        int          stall_cyc;
        int          req_cyc;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
    } exp_t;

    exp_t sb[$];

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_funct3  (req_funct3),
        .req_address (req_address),
        .req_wdata   (req_wdata),
        .stall       (stall),
        .rsp_rdata   (rsp_rdata),
        .fault       (fault),
        .fault_cause (fault_cause),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drives one request and plays memory: ready after ready_lat valid cycles (-1 never),
    // rvalid rvalid_lat cycles after the handshake (0 = same cycle, -1 never).
    task automatic run_txn(input string tag, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int ready_lat, input int rvalid_lat, input logic [31:0] rdata,
                           input logic [31:0] exp_rdata, input logic [1:0] exp_cause,
                           input int exp_stall, input int exp_req,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        exp_t e;
        int   vcnt = 0;
        int   wcnt = 0;
        int   stall_cyc = 0;
        int   guard = 0;
        bit   accepted = 0;
        bit   done = 0;
        e.tag = tag; e.rdata = exp_rdata; e.cause = exp_cause;
        e.stall_cyc = exp_stall; e.req_cyc = exp_req; e.be = exp_be;
        e.addr = {addr[31:2], 2'b00}; e.wdata = exp_wdata; e.wr = wr;
        sb.push_back(e);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_address = addr; req_wdata = wdata;
        while (!done && guard < 50) begin
            @(negedge clk);
            guard++;
            bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
            if (stall === 1'b0) begin
                done = 1;
            end else begin
                stall_cyc++;
                if (bus.mem_valid === 1'b1) begin
                    if (vcnt == 0) begin
                        check({sb[0].tag, " mem_be"}, 32'(bus.mem_be), 32'(sb[0].be));
                        check({sb[0].tag, " mem_address"}, bus.mem_address, sb[0].addr);
                        check({sb[0].tag, " mem_we"}, 32'(bus.mem_we), 32'(sb[0].wr));
                        if (wr) check({sb[0].tag, " mem_wdata"}, bus.mem_wdata, sb[0].wdata);
                    end
                    if (ready_lat >= 0 && vcnt >= ready_lat) begin
                        bus.mem_ready = 1'b1;
                        accepted = 1;
                        if (!wr && rvalid_lat == 0) begin
                            bus.mem_rvalid = 1'b1; bus.mem_rdata = rdata;
                        end
                    end
                    vcnt++;
                end else if (accepted && !wr) begin
                    wcnt++;
                    if (rvalid_lat >= 0 && wcnt >= rvalid_lat) begin
                        bus.mem_rvalid = 1'b1; bus.mem_rdata = rdata;
                    end
                end
            end
        end
        e = sb.pop_front();
        check({e.tag, " completes"}, 32'(done), 32'd1);
        check({e.tag, " rsp_rdata"}, rsp_rdata, e.rdata);
        check({e.tag, " fault"}, 32'(fault), 32'(e.cause != 2'b00));
        check({e.tag, " fault_cause"}, 32'(fault_cause), 32'(e.cause));
        check({e.tag, " stall cycles"}, 32'(stall_cyc), 32'(e.stall_cyc));
        check({e.tag, " mem_valid cycles"}, 32'(vcnt), 32'(e.req_cyc));
        $display("[TB] %s: rsp_rdata=0x%08h fault=%0b cause=%0d stall_cycles=%0d",
                 e.tag, rsp_rdata, fault, fault_cause, stall_cyc);
        req_valid = 1'b0;
        @(negedge clk);
        check({e.tag, " fault one cycle"}, 32'(fault), 32'd0);
        check({e.tag, " idle mem_valid"}, 32'(bus.mem_valid), 32'd0);
    endtask

    initial begin
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset stall", 32'(stall), 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'd0);
        check("reset fault", 32'(fault), 32'd0);
        check("reset fault_cause", 32'(fault_cause), 32'd0);
        check("reset mem_valid", 32'(bus.mem_valid), 32'd0);
        check("reset mem_we", 32'(bus.mem_we), 32'd0);
        check("reset mem_be", 32'(bus.mem_be), 32'd0);
        $display("[TB] reset: state checked");

        //      tag                wr    f3      addr          wdata         rdy rv  rdata         exp_rdata     cause  st rq be       exp_wdata
        run_txn("LW 0x100",        1'b0, 3'b010, 32'h0000_0100, 32'h0,        0,  1, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 2, 1, 4'b1111, 32'h0);
        run_txn("LB 0x103",        1'b0, 3'b000, 32'h0000_0103, 32'h0,        0,  1, 32'h80FF0000, 32'hFFFFFF80, 2'b00, 2, 1, 4'b1111, 32'h0);
        run_txn("LBU 0x103",       1'b0, 3'b100, 32'h0000_0103, 32'h0,        0,  1, 32'h80FF0000, 32'h00000080, 2'b00, 2, 1, 4'b1111, 32'h0);
        run_txn("SH 0x202",        1'b1, 3'b001, 32'h0000_0202, 32'h1234ABCD, 2,  0, 32'h0,        32'h00000000, 2'b00, 3, 3, 4'b1100, 32'hABCDABCD);
        run_txn("SB 0x001",        1'b1, 3'b000, 32'h0000_0001, 32'h000000A5, 0,  0, 32'h0,        32'h00000000, 2'b00, 1, 1, 4'b0010, 32'hA5A5A5A5);
        run_txn("LH 0x102 rv0",    1'b0, 3'b001, 32'h0000_0102, 32'h0,        0,  0, 32'h80017FFF, 32'hFFFF8001, 2'b00, 1, 1, 4'b1111, 32'h0);
        run_txn("LW 0x101 misal",  1'b0, 3'b010, 32'h0000_0101, 32'h0,        0,  1, 32'h11111111, 32'h00000000, 2'b01, 0, 0, 4'b1111, 32'h0);
        run_txn("LHU 0x102 rv2",   1'b0, 3'b101, 32'h0000_0102, 32'h0,        1,  2, 32'h80017FFF, 32'h00008001, 2'b00, 4, 2, 4'b1111, 32'h0);
        run_txn("load f3 011",     1'b0, 3'b011, 32'h0000_0100, 32'h0,        0,  1, 32'h22222222, 32'h00000000, 2'b11, 0, 0, 4'b1111, 32'h0);
        run_txn("SW 0x40",         1'b1, 3'b010, 32'h0000_0040, 32'h55AA33CC, 1,  0, 32'h0,        32'h00000000, 2'b00, 2, 2, 4'b1111, 32'h55AA33CC);
        run_txn("store f3 100",    1'b1, 3'b100, 32'h0000_0100, 32'h12345678, 0,  0, 32'h0,        32'h00000000, 2'b11, 0, 0, 4'b1111, 32'h0);
        run_txn("SH 0x203 misal",  1'b1, 3'b001, 32'h0000_0203, 32'h12345678, 0,  0, 32'h0,        32'h00000000, 2'b01, 0, 0, 4'b1111, 32'h0);
        run_txn("timeout in REQ",  1'b0, 3'b010, 32'h0000_0080, 32'h0,        -1, 1, 32'h33333333, 32'h00000000, 2'b10, 4, 4, 4'b1111, 32'h0);
        run_txn("timeout in WAIT", 1'b0, 3'b010, 32'h0000_0084, 32'h0,        0, -1, 32'h44444444, 32'h00000000, 2'b10, 4, 1, 4'b1111, 32'h0);
        run_txn("LW 0x10",         1'b0, 3'b010, 32'h0000_0010, 32'h0,        1,  1, 32'hCAFEF00D, 32'hCAFEF00D, 2'b00, 3, 2, 4'b1111, 32'h0);

        // Reset during WAIT: the access is abandoned and a late rvalid must not land.
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_address = 32'h0000_0040;
        @(negedge clk);
        check("rst-wait in REQ", 32'(bus.mem_valid), 32'd1);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        check("rst-wait in WAIT", 32'(bus.mem_valid), 32'd0);
        reset_n = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("rst-wait mem_valid", 32'(bus.mem_valid), 32'd0);
        check("rst-wait rsp cleared", rsp_rdata, 32'd0);
        reset_n = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h12345678;
        @(negedge clk);
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        check("rst-wait late rdata", rsp_rdata, 32'd0);
        check("rst-wait fault", 32'(fault), 32'd0);
        check("rst-wait fault_cause", 32'(fault_cause), 32'd0);
        check("rst-wait mem_valid after", 32'(bus.mem_valid), 32'd0);
        $display("[TB] reset during WAIT: rsp_rdata=0x%08h fault=%0b", rsp_rdata, fault);

        run_txn("LB 0x301 post-rst", 1'b0, 3'b000, 32'h0000_0301, 32'h0,      0,  1, 32'h00007F00, 32'h0000007F, 2'b00, 2, 1, 4'b1111, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: REQ+WAIT cycles allowed before a bus fault; range 1..255.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 reset_n  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 req_valid  in  1  core presents a load/store; held until stall is low.
REQ-005 req_write  in  1  1 = store, 0 = load.
REQ-006 req_funct3  in  3  RV32I width/sign code.
REQ-007 req_address  in  32  byte address from the ALU result.
REQ-008 req_wdata  in  32  store data from register source 2.
REQ-009 stall  out  1  holds the core's PC and register write while the access is in flight.
REQ-010 rsp_rdata  out  32  extended load result, valid while stall is low.
REQ-011 fault  out  1  one-cycle pulse in DONE when the access failed.
REQ-012 fault_cause  out  2  01 misaligned, 10 timeout, 11 illegal funct3, 00 none.
REQ-013 mem_valid / mem_ready  out/in  1/1  request handshake to data memory.
REQ-014 mem_we  out  1; mem_be  out  4; mem_address  out  32; mem_wdata  out  32  request payload.
REQ-015 mem_rvalid  in  1; mem_rdata  in  32  read response.

Function
REQ-016 FSM states IDLE, REQ, WAIT, DONE.
REQ-017 IDLE: req_valid with legal, aligned access -> REQ, capturing address, funct3, write, wdata.
REQ-018 IDLE: misaligned (LH/LHU/SH addr[0]=1; LW/SW addr[1:0]!=0) or illegal funct3 (011, 110, 111; 100/101 with store) -> DONE with cause; no memory request.
REQ-019 REQ: mem_valid=1 with stable payload until mem_ready; store+ready -> DONE; load+ready -> WAIT, or DONE directly if mem_rvalid is also high that cycle.
REQ-020 WAIT: mem_rvalid -> capture extended data, DONE; mem_rvalid outside REQ/WAIT ignored.
REQ-021 DONE: stall=0 for exactly one cycle, fault asserted if cause!=00, then -> IDLE.
REQ-022 stall = req_valid and state!=DONE (combinational).
REQ-023 8-bit counter clears entering REQ, increments each REQ/WAIT cycle; reaching TIMEOUT_CYCLES -> DONE, cause 10, rsp_rdata=0.
REQ-024 mem_address = {addr[31:2], 2'b00}.
REQ-025 SB: mem_be = 1<<addr[1:0], byte replicated on all four lanes; SH: 0011 (addr[1]=0) or 1100, halfword replicated; SW: 1111.
REQ-026 Loads: mem_be 1111; LB/LH sign-extend, LBU/LHU zero-extend the lane selected by addr[1:0]; LW unchanged.
REQ-027 Faulted access: rsp_rdata=0, no register-visible data.
REQ-028 req_valid dropping mid-transaction does not abort it; FSM still completes to DONE.
REQ-029 Back-to-back: request present in the cycle after DONE is accepted from IDLE normally (minimum 1 idle cycle).

Reset
REQ-030 reset_n low: state IDLE, counter 0, captured regs 0, rsp_rdata 0, fault 0, fault_cause 00, mem_valid 0, mem_we 0, mem_be 0000.
REQ-031 Reset mid-REQ/WAIT abandons the access; mem_valid low from the next cycle; a late mem_rvalid is ignored.

Structure
REQ-032 lsu_state_t enum, funct3 constants (LB..LHU) and fault cause enum live in pkg.
REQ-033 One sub-module, load_extender (combinational lane select + sign/zero extension), is natural.
REQ-034 Instantiated in cpu between the ALU result / register read data and the data memory.

Verification
REQ-035 LW addr 0x100, mem_ready same cycle, rvalid next with 0xDEADBEEF -> rsp_rdata 0xDEADBEEF, stall high 2 cycles.
REQ-036 LB addr 0x103, rdata 0x80FF0000 -> rsp_rdata 0xFFFFFF80; LBU same -> 0x00000080.
REQ-037 SH addr 0x202, wdata 0x1234ABCD -> mem_be 1100, mem_wdata 0xABCDABCD, mem_address 0x200.
REQ-038 LW addr 0x101 -> no mem_valid, fault pulse, cause 01, rsp_rdata 0.
REQ-039 TIMEOUT_CYCLES=4, mem_ready held low -> fault cause 10 after 4 REQ cycles, then IDLE.
REQ-040 reset_n low during WAIT, then rvalid -> state IDLE, rsp_rdata stays 0, no fault.
